// File: rtl/exec_pkg.sv
// Shared encodings and payload types for the multi-cycle execute unit.
package exec_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned OP_W    = 4;
  localparam int unsigned FU_W    = 2;
  localparam int unsigned SHAMT_W = 5;
  localparam int unsigned IMM_W   = 16;

  // ALU operation codes (fu_sel = ALU)
  localparam logic [OP_W-1:0] ALU_AND = 4'b0000;
  localparam logic [OP_W-1:0] ALU_OR  = 4'b0001;
  localparam logic [OP_W-1:0] ALU_ADD = 4'b0010;
  localparam logic [OP_W-1:0] ALU_SUB = 4'b0110;
  localparam logic [OP_W-1:0] ALU_SLT = 4'b0111;
  localparam logic [OP_W-1:0] ALU_NOR = 4'b1100;

  // Shift operation codes (fu_sel = SHIFT)
  localparam logic [OP_W-1:0] SH_SLL  = 4'b0000;
  localparam logic [OP_W-1:0] SH_SRL  = 4'b0001;
  localparam logic [OP_W-1:0] SH_SLLV = 4'b0010;
  localparam logic [OP_W-1:0] SH_SRLV = 4'b0011;

  // Functional-unit select codes; 2'b11 is illegal
  localparam logic [FU_W-1:0] FU_ALU   = 2'b00;
  localparam logic [FU_W-1:0] FU_SHIFT = 2'b01;
  localparam logic [FU_W-1:0] FU_LUI   = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_HOLD  = 2'b10
  } state_t;

  // Registered writeback payload
  typedef struct packed {
    logic [XLEN-1:0] result;
    logic            zero;
    logic            ovf;
    logic            err;
  } exec_out_t;

endpackage

// File: rtl/exec_shifter.sv
// Iterative logical shifter: moves up to STEP bits per step until the count is exhausted.
module exec_shifter
  import exec_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned STEP   = 1
) (
  input  logic               clk_i,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic               step_i,
  input  logic               left_i,
  input  logic [SHAMT_W-1:0] amount_i,
  input  logic [DATA_W-1:0]  operand_i,
  output logic [DATA_W-1:0]  next_c,
  output logic               done_c
);

  logic [DATA_W-1:0]  opnd_q;
  logic [SHAMT_W-1:0] rem_q;
  logic [SHAMT_W-1:0] step_amt;
  logic               left_q;

  // Per-step amount, shifted value, and "this step finishes the shift" flag
  always_comb begin
    step_amt = (rem_q < SHAMT_W'(STEP)) ? rem_q : SHAMT_W'(STEP);
    next_c   = left_q ? (opnd_q << step_amt) : (opnd_q >> step_amt);
    done_c   = (rem_q <= SHAMT_W'(STEP));
  end

  // Operand, remaining count and direction registers
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      opnd_q <= '0;
      rem_q  <= '0;
      left_q <= 1'b0;
    end else if (start_i) begin
      opnd_q <= operand_i;
      rem_q  <= amount_i;
      left_q <= left_i;
    end else if (step_i && (rem_q != '0)) begin
      opnd_q <= next_c;
      rem_q  <= rem_q - step_amt;
    end
  end

endmodule

// File: rtl/exec_unit.sv
// Multi-cycle execute unit: single-cycle ALU/lui, iterative shifter, valid/ready on both sides.
module exec_unit
  import exec_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned SHIFT_STEP = 1
) (
  input  logic               clk_i,
  input  logic               rst_n,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [OP_W-1:0]    alu_op_i,
  input  logic [FU_W-1:0]    fu_sel_i,
  input  logic [DATA_W-1:0]  src1_i,
  input  logic [DATA_W-1:0]  src2_i,
  input  logic [SHAMT_W-1:0] shamt_i,
  input  logic [IMM_W-1:0]   imm_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [DATA_W-1:0]  result_o,
  output logic               zero_o,
  output logic               ovf_o,
  output logic               err_o
);

  state_t             state_q, state_d;
  exec_out_t          out_q, out_d;
  logic               in_ready_q;
  logic               out_valid_q;
  logic               accept;

  logic [DATA_W-1:0]  sum, diff, alu_res;
  logic               alu_ovf, alu_err;

  logic               sh_legal, sh_left, sh_start, sh_step, sh_done;
  logic [SHAMT_W-1:0] sh_amt;
  logic [DATA_W-1:0]  sh_next;

  assign accept   = in_valid_i && in_ready_q;
  assign sh_legal = alu_op_i inside {SH_SLL, SH_SRL, SH_SLLV, SH_SRLV};
  assign sh_left  = (alu_op_i == SH_SLL) || (alu_op_i == SH_SLLV);
  assign sh_amt   = ((alu_op_i == SH_SLLV) || (alu_op_i == SH_SRLV)) ?
                    src1_i[SHAMT_W-1:0] : shamt_i;

  // Single-cycle ALU with signed-overflow detect for add/sub
  always_comb begin
    sum     = src1_i + src2_i;
    diff    = src1_i - src2_i;
    alu_res = '0;
    alu_ovf = 1'b0;
    alu_err = 1'b0;
    case (alu_op_i)
      ALU_AND: alu_res = src1_i & src2_i;
      ALU_OR:  alu_res = src1_i | src2_i;
      ALU_NOR: alu_res = ~(src1_i | src2_i);
      ALU_ADD: begin
        alu_res = sum;
        alu_ovf = (src1_i[DATA_W-1] == src2_i[DATA_W-1]) &&
                  (sum[DATA_W-1] != src1_i[DATA_W-1]);
      end
      ALU_SUB: begin
        alu_res = diff;
        alu_ovf = (src1_i[DATA_W-1] != src2_i[DATA_W-1]) &&
                  (diff[DATA_W-1] != src1_i[DATA_W-1]);
      end
      ALU_SLT: alu_res = DATA_W'($signed(src1_i) < $signed(src2_i));
      default: alu_err = 1'b1;
    endcase
  end

  exec_shifter #(
    .DATA_W (DATA_W),
    .STEP   (SHIFT_STEP)
  ) u_shifter (
    .clk_i     (clk_i),
    .rst_n     (rst_n),
    .start_i   (sh_start),
    .step_i    (sh_step),
    .left_i    (sh_left),
    .amount_i  (sh_amt),
    .operand_i (src2_i),
    .next_c    (sh_next),
    .done_c    (sh_done)
  );

  // Next-state and next-payload decode
  always_comb begin
    state_d  = state_q;
    out_d    = out_q;
    sh_start = 1'b0;
    sh_step  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          out_d   = '0;
          state_d = ST_HOLD;
          case (fu_sel_i)
            FU_ALU: begin
              out_d.result = alu_res;
              out_d.ovf    = alu_ovf;
              out_d.err    = alu_err;
            end
            FU_LUI: out_d.result = DATA_W'({imm_i, 16'h0000});
            FU_SHIFT: begin
              if (!sh_legal) begin
                out_d.err = 1'b1;
              end else if (sh_amt == '0) begin
                out_d.result = src2_i;
              end else begin
                sh_start = 1'b1;
                state_d  = ST_SHIFT;
              end
            end
            default: out_d.err = 1'b1;
          endcase
          out_d.zero = (out_d.result == '0);
        end
      end
      ST_SHIFT: begin
        sh_step = 1'b1;
        if (sh_done) begin
          state_d      = ST_HOLD;
          out_d.result = sh_next;
          out_d.zero   = (sh_next == '0);
        end
      end
      ST_HOLD: begin
        if (out_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, payload and handshake registers
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      out_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_q       <= out_d;
      in_ready_q  <= (state_d == ST_IDLE);
      out_valid_q <= (state_d == ST_HOLD);
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign result_o    = out_q.result;
  assign zero_o      = out_q.zero;
  assign ovf_o       = out_q.ovf;
  assign err_o       = out_q.err;

endmodule
